// File: rtl/dm_axi_master_pkg.sv
// Shared AXI4 widths, encodings and helpers for the data-memory master.
package dm_axi_master_pkg;

  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_STRB_W  = AXI_DATA_W / 8;
  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] BURST_INCR = 2'b01;
  localparam logic [AXI_SIZE_W-1:0]  SIZE_WORD  = 3'b010;
  localparam logic [AXI_RESP_W-1:0]  RESP_OKAY  = 2'b00;
  localparam logic [AXI_LEN_W-1:0]   LEN_SINGLE = '0;

  // Any response other than OKAY is reported to the CPU as an error.
  function automatic logic resp_is_err(input logic [AXI_RESP_W-1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/dm_axi_master.sv
// Data-memory AXI4 master: turns one CPU load/store at a time into a
// single-beat AXI transaction and holds the CPU pipeline until it completes.
module dm_axi_master
  import dm_axi_master_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] MASTER_ID = 4'd1
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  // CPU load/store unit side
  input  logic                   cpu_req,
  input  logic [AXI_STRB_W-1:0]  cpu_we,
  input  logic [AXI_ADDR_W-1:0]  cpu_addr,
  input  logic [AXI_DATA_W-1:0]  cpu_wdata,
  output logic [AXI_DATA_W-1:0]  cpu_rdata,
  output logic                   cpu_stall,
  output logic                   cpu_err,
  // AW channel
  output logic [AXI_ID_W-1:0]    AWID,
  output logic [AXI_ADDR_W-1:0]  AWADDR,
  output logic [AXI_LEN_W-1:0]   AWLEN,
  output logic [AXI_SIZE_W-1:0]  AWSIZE,
  output logic [AXI_BURST_W-1:0] AWBURST,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  // W channel
  output logic [AXI_DATA_W-1:0]  WDATA,
  output logic [AXI_STRB_W-1:0]  WSTRB,
  output logic                   WLAST,
  output logic                   WVALID,
  input  logic                   WREADY,
  // B channel
  input  logic [AXI_ID_W-1:0]    BID,
  input  logic [AXI_RESP_W-1:0]  BRESP,
  input  logic                   BVALID,
  output logic                   BREADY,
  // AR channel
  output logic [AXI_ID_W-1:0]    ARID,
  output logic [AXI_ADDR_W-1:0]  ARADDR,
  output logic [AXI_LEN_W-1:0]   ARLEN,
  output logic [AXI_SIZE_W-1:0]  ARSIZE,
  output logic [AXI_BURST_W-1:0] ARBURST,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  // R channel
  input  logic [AXI_ID_W-1:0]    RID,
  input  logic [AXI_DATA_W-1:0]  RDATA,
  input  logic [AXI_RESP_W-1:0]  RRESP,
  input  logic                   RLAST,
  input  logic                   RVALID,
  output logic                   RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_e;

  state_e                  state_q;
  logic [AXI_ADDR_W-1:0]   addr_q;
  logic [AXI_STRB_W-1:0]   we_q;
  logic [AXI_DATA_W-1:0]   wdata_q;
  logic [AXI_DATA_W-1:0]   rdata_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic                    aw_done_q;
  logic                    w_done_q;
  logic                    err_q;

  logic                    ar_hs;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    r_done;
  logic                    b_done;
  logic                    aw_done_d;
  logic                    w_done_d;

  // IDs play no part in control: this master only ever has one transaction
  // in flight, so the response always belongs to it.
  logic                    unused_ids;
  assign unused_ids = ^{RID, BID};

  assign ar_hs     = arvalid_q & ARREADY;
  assign aw_hs     = awvalid_q & AWREADY;
  assign w_hs      = wvalid_q & WREADY;
  assign r_done    = (state_q == RD_DATA) & rready_q & RVALID & RLAST;
  assign b_done    = (state_q == WR_RESP) & bready_q & BVALID;
  assign aw_done_d = aw_done_q | aw_hs;
  assign w_done_d  = w_done_q | w_hs;

  // Transaction sequencer: latches the CPU request, drives each AXI channel
  // from registers, and fires a one-cycle error pulse after a bad response.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            if (cpu_we == '0) begin
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WR_REQ;
            end
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_done) begin
            rready_q <= 1'b0;
            rdata_q  <= RDATA;
            err_q    <= resp_is_err(RRESP);
            state_q  <= IDLE;
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          // Both halves done (possibly in this very cycle): the flags are
          // cleared here so the next write starts from a clean slate.
          if (aw_done_d && w_done_d) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_done) begin
            bready_q <= 1'b0;
            err_q    <= resp_is_err(BRESP);
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The CPU is released only in the cycle the final response handshakes,
  // and a fresh request always costs at least one stalled IDLE cycle.
  assign cpu_stall = (state_q == IDLE) ? cpu_req : ~(r_done | b_done);
  assign cpu_rdata = r_done ? RDATA : rdata_q;
  assign cpu_err   = err_q;

  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = LEN_SINGLE;
  assign AWSIZE  = SIZE_WORD;
  assign AWBURST = BURST_INCR;
  assign AWVALID = awvalid_q;

  assign WDATA   = wdata_q;
  assign WSTRB   = we_q;
  assign WLAST   = 1'b1;
  assign WVALID  = wvalid_q;

  assign BREADY  = bready_q;

  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = LEN_SINGLE;
  assign ARSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;
  assign ARVALID = arvalid_q;

  assign RREADY  = rready_q;

endmodule

// File: tb/tb_dm_axi_master.sv
// Randomised scoreboard bench for dm_axi_master with a behavioural AXI slave.
module tb_dm_axi_master;

  localparam logic [3:0]  MID     = 4'd5;
  localparam logic [31:0] BASE    = 32'h0001_0000;
  localparam int          NWORDS  = 16;
  localparam int          NTXN    = 300;
  localparam int          TIMEOUT = 100;

  logic        ACLK;
  logic        ARESETn;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  dm_axi_master #(.MASTER_ID(MID)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Free-running 100 MHz clock.
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          isRead;
    logic [31:0] data;
    bit          err;
  } cpu_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_exp_t;

  cpu_exp_t    cpuQ[$];
  logic [31:0] arQ[$];
  logic [31:0] awQ[$];
  w_exp_t      wQ[$];

  logic [31:0] refMem [NWORDS];
  logic [31:0] slvMem [NWORDS];

  int nChecks = 0;
  int nFails  = 0;
  bit quiet = 1'b0;
  bit forceReady = 1'b0;

  // Two words of the map form an erroring region: reads get SLVERR,
  // writes get DECERR and leave memory untouched.
  function automatic bit isBad(input int idx);
    return (idx == 13) || (idx == 14);
  endfunction

  function automatic int addrToIdx(input logic [31:0] a);
    return int'((a - BASE) >> 2) & (NWORDS - 1);
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic finishTest();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  endtask

  // Issue one CPU access: record what the outside world must see, drive
  // the request, then wait (bounded) for the cycle the CPU is released.
  task automatic applyStimulus(input bit isRead, input int idx, input logic [3:0] we,
                               input logic [31:0] wdata, input bit holdReq, output int lat);
    cpu_exp_t    e;
    w_exp_t      w;
    logic [31:0] addr;
    int          cycles;
    bit          done;
    addr     = BASE + 32'(idx << 2);
    e.isRead = isRead;
    e.err    = isBad(idx);
    e.data   = refMem[idx];
    cpuQ.push_back(e);
    if (isRead) begin
      arQ.push_back(addr);
    end else begin
      w.data = wdata;
      w.strb = we;
      awQ.push_back(addr);
      wQ.push_back(w);
      if (!e.err) refMem[idx] = mergeBytes(refMem[idx], wdata, we);
    end
    cpu_req   = 1'b1;
    cpu_we    = isRead ? 4'b0000 : we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(posedge ACLK); #1;
    cpu_we    = 4'($urandom);
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < TIMEOUT) begin
      @(negedge ACLK);
      cycles++;
      if (cpu_stall == 1'b0) done = 1'b1;
    end
    lat = cycles + 1;
    if (!done) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL txn_timeout: got no completion after %0d cycles, expected completion (t=%0t)",
               TIMEOUT, $time);
      finishTest();
    end
    @(posedge ACLK); #1;
    if (!holdReq) begin
      cpu_req = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge ACLK);
      #1;
    end
  endtask

  // Behavioural AXI slave: random READY timing, random response latency,
  // junk on idle data buses and random IDs to show they are ignored.
  initial begin
    bit          arHs, awHs, wHs, rHs, bHs;
    bit          rPend, awGot, wGot, bPend, bBad;
    logic [31:0] arA, awA, wD, wData;
    logic [3:0]  wS, wStrb;
    int          rIdx, wIdx, rDelay, bDelay;
    ARREADY = 0; AWREADY = 0; WREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RID = 0;
    BVALID = 0; BRESP = 0; BID = 0;
    rPend = 0; awGot = 0; wGot = 0; bPend = 0; bBad = 0;
    rIdx = 0; wIdx = 0; rDelay = 0; bDelay = 0; wData = 0; wStrb = 0;
    forever begin
      @(negedge ACLK);
      arHs = ARESETn && ARVALID && ARREADY;
      awHs = ARESETn && AWVALID && AWREADY;
      wHs  = ARESETn && WVALID && WREADY;
      rHs  = ARESETn && RVALID && RREADY;
      bHs  = ARESETn && BVALID && BREADY;
      arA = ARADDR; awA = AWADDR; wD = WDATA; wS = WSTRB;
      @(posedge ACLK); #1;
      if (!ARESETn) begin
        rPend = 0; awGot = 0; wGot = 0; bPend = 0;
        RVALID = 0; BVALID = 0; ARREADY = 0; AWREADY = 0; WREADY = 0;
        continue;
      end
      if (rHs) RVALID = 1'b0;
      if (bHs) BVALID = 1'b0;
      if (arHs) begin
        rPend  = 1'b1;
        rIdx   = addrToIdx(arA);
        rDelay = forceReady ? 0 : int'($urandom_range(0, 3));
      end
      if (awHs) begin
        awGot = 1'b1;
        wIdx  = addrToIdx(awA);
      end
      if (wHs) begin
        wGot  = 1'b1;
        wData = wD;
        wStrb = wS;
      end
      if (awGot && wGot) begin
        bBad = isBad(wIdx);
        if (!bBad) slvMem[wIdx] = mergeBytes(slvMem[wIdx], wData, wStrb);
        bPend  = 1'b1;
        bDelay = forceReady ? 0 : int'($urandom_range(0, 3));
        awGot  = 1'b0;
        wGot   = 1'b0;
      end
      if (rPend) begin
        if (rDelay == 0) begin
          rPend  = 1'b0;
          RVALID = 1'b1;
          RDATA  = slvMem[rIdx];
          RRESP  = isBad(rIdx) ? 2'b10 : 2'b00;
          RLAST  = 1'b1;
          RID    = 4'($urandom);
        end else begin
          rDelay--;
        end
      end
      if (bPend) begin
        if (bDelay == 0) begin
          bPend  = 1'b0;
          BVALID = 1'b1;
          BRESP  = bBad ? 2'b11 : 2'b00;
          BID    = 4'($urandom);
        end else begin
          bDelay--;
        end
      end
      if (!RVALID) begin
        RDATA = $urandom;
        RRESP = 2'($urandom);
        RLAST = 1'($urandom);
      end
      if (!BVALID) BRESP = 2'($urandom);
      if (quiet) begin
        ARREADY = 0; AWREADY = 0; WREADY = 0;
      end else if (forceReady) begin
        ARREADY = 1; AWREADY = 1; WREADY = 1;
      end else begin
        ARREADY = 1'($urandom); AWREADY = 1'($urandom); WREADY = 1'($urandom);
      end
    end
  end

  // CPU-side monitor: pops the scoreboard on every completing R/B handshake
  // and checks stall, load data and the delayed error pulse every cycle.
  initial begin
    cpu_exp_t    e;
    logic [31:0] lastRd;
    bit          errExp, rHs, bHs;
    lastRd = 0;
    errExp = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        lastRd = 0;
        errExp = 0;
        continue;
      end
      rHs = RVALID && RREADY && RLAST;
      bHs = BVALID && BREADY;
      checkOutput("cpu_err", 32'(cpu_err), 32'(errExp));
      errExp = 1'b0;
      if (rHs || bHs) begin
        checkOutput("stall_at_done", 32'(cpu_stall), 32'd0);
        if (cpuQ.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = cpuQ.pop_front();
          checkOutput("done_kind_read", 32'(rHs), 32'(e.isRead));
          if (rHs) begin
            checkOutput("cpu_rdata_live", cpu_rdata, e.data);
            lastRd = e.data;
          end else begin
            checkOutput("cpu_rdata_held", cpu_rdata, lastRd);
          end
          errExp = e.err;
        end
      end else begin
        checkOutput("cpu_stall", 32'(cpu_stall), 32'(cpuQ.size() != 0));
        checkOutput("cpu_rdata_held", cpu_rdata, lastRd);
      end
    end
  end

  // AXI-side monitor: request payload on every handshake, VALID stability
  // while waiting, and read/write channels never active together.
  initial begin
    bit          pArV, pArR, pAwV, pAwR, pWV, pWR;
    logic [31:0] pArA, pAwA, pWD, a;
    w_exp_t      w;
    pArV = 0; pArR = 0; pAwV = 0; pAwR = 0; pWV = 0; pWR = 0;
    pArA = 0; pAwA = 0; pWD = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        pArV = 0; pAwV = 0; pWV = 0;
        continue;
      end
      if (pArV && !pArR) begin
        checkOutput("ar_hold", 32'(ARVALID), 32'd1);
        checkOutput("araddr_hold", ARADDR, pArA);
      end
      if (pAwV && !pAwR) begin
        checkOutput("aw_hold", 32'(AWVALID), 32'd1);
        checkOutput("awaddr_hold", AWADDR, pAwA);
      end
      if (pWV && !pWR) begin
        checkOutput("w_hold", 32'(WVALID), 32'd1);
        checkOutput("wdata_hold", WDATA, pWD);
      end
      if (ARVALID) checkOutput("ar_exclusive", 32'({AWVALID, WVALID, BREADY, RREADY}), 32'd0);
      if (ARVALID && ARREADY) begin
        if (arQ.size() == 0) begin
          checkOutput("unexpected_ar", 32'd1, 32'd0);
        end else begin
          a = arQ.pop_front();
          checkOutput("araddr", ARADDR, a);
          checkOutput("ar_attr", 32'({ARID, ARLEN, ARSIZE, ARBURST}), 32'({MID, 4'd0, 3'b010, 2'b01}));
        end
      end
      if (AWVALID && AWREADY) begin
        if (awQ.size() == 0) begin
          checkOutput("unexpected_aw", 32'd1, 32'd0);
        end else begin
          a = awQ.pop_front();
          checkOutput("awaddr", AWADDR, a);
          checkOutput("aw_attr", 32'({AWID, AWLEN, AWSIZE, AWBURST}), 32'({MID, 4'd0, 3'b010, 2'b01}));
        end
      end
      if (WVALID && WREADY) begin
        if (wQ.size() == 0) begin
          checkOutput("unexpected_w", 32'd1, 32'd0);
        end else begin
          w = wQ.pop_front();
          checkOutput("wdata", WDATA, w.data);
          checkOutput("wstrb_wlast", 32'({WLAST, WSTRB}), 32'({1'b1, w.strb}));
        end
      end
      pArV = ARVALID; pArR = ARREADY; pArA = ARADDR;
      pAwV = AWVALID; pAwR = AWREADY; pAwA = AWADDR;
      pWV  = WVALID;  pWR  = WREADY;  pWD  = WDATA;
    end
  end

  // Main sequence: reset checks, directed corner cases, random traffic,
  // reset in the middle of a write, then a final drain check.
  initial begin
    int lat;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    for (int i = 0; i < NWORDS; i++) begin
      refMem[i] = 32'hA5A5_0000 | 32'(i);
      slvMem[i] = refMem[i];
    end
    refMem[4] = 32'hDEAD_BEEF;
    slvMem[4] = 32'hDEAD_BEEF;
    ARESETn = 1'b1;
    #2 ARESETn = 1'b0;
    @(negedge ACLK);
    $display("[TB] reset state checks");
    checkOutput("rst_valids", 32'({ARVALID, AWVALID, WVALID}), 32'd0);
    checkOutput("rst_readys", 32'({RREADY, BREADY}), 32'd0);
    checkOutput("rst_cpu_err", 32'(cpu_err), 32'd0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
    checkOutput("rst_stall_noreq", 32'(cpu_stall), 32'd0);
    cpu_req = 1'b1;
    #1 checkOutput("rst_stall_req", 32'(cpu_stall), 32'd1);
    cpu_req = 1'b0;
    @(posedge ACLK); #1 ARESETn = 1'b1;

    $display("[TB] directed load of 0x00010010");
    applyStimulus(1'b1, 4, 4'b0000, 32'h0, 1'b0, lat);
    applyStimulus(1'b0, 2, 4'b0011, 32'h1234_5678, 1'b1, lat);
    applyStimulus(1'b1, 2, 4'b0000, 32'h0, 1'b0, lat);
    applyStimulus(1'b1, 13, 4'b0000, 32'h0, 1'b0, lat);

    $display("[TB] random traffic");
    for (int t = 0; t < NTXN; t++) begin
      applyStimulus(1'($urandom), int'($urandom_range(0, NWORDS - 1)), 4'($urandom_range(1, 15)),
                    $urandom, 1'($urandom), lat);
    end

    $display("[TB] always-ready latency");
    forceReady = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    applyStimulus(1'b0, 7, 4'b1111, 32'hCAFE_F00D, 1'b0, lat);
    checkOutput("write_latency", 32'(lat), 32'd3);
    applyStimulus(1'b1, 7, 4'b0000, 32'h0, 1'b1, lat);
    checkOutput("read_latency", 32'(lat), 32'd3);
    applyStimulus(1'b0, 14, 4'b1100, 32'h5555_AAAA, 1'b0, lat);
    forceReady = 1'b0;

    $display("[TB] reset during write request");
    quiet = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    begin
      cpu_exp_t e;
      w_exp_t   w;
      e.isRead = 1'b0; e.data = 32'h0; e.err = 1'b0;
      w.data = 32'h7777_7777; w.strb = 4'b1111;
      cpuQ.push_back(e);
      awQ.push_back(BASE);
      wQ.push_back(w);
    end
    cpu_req = 1'b1; cpu_we = 4'b1111; cpu_addr = BASE; cpu_wdata = 32'h7777_7777;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("pre_rst_awvalid", 32'({AWVALID, WVALID}), 32'b11);
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    #1;
    checkOutput("midrst_valids", 32'({ARVALID, AWVALID, WVALID, RREADY, BREADY}), 32'd0);
    checkOutput("midrst_stall_req", 32'(cpu_stall), 32'd1);
    cpu_req = 1'b0;
    cpuQ.delete();
    awQ.delete();
    wQ.delete();
    #1;
    checkOutput("midrst_stall_noreq", 32'(cpu_stall), 32'd0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    quiet = 1'b0;
    @(negedge ACLK);
    checkOutput("postrst_stall", 32'(cpu_stall), 32'd0);
    @(posedge ACLK); #1;
    for (int t = 0; t < 30; t++) begin
      applyStimulus(1'($urandom), int'($urandom_range(0, NWORDS - 1)), 4'($urandom_range(1, 15)),
                    $urandom, 1'($urandom), lat);
    end
    for (int i = 0; i < NWORDS; i++) begin
      applyStimulus(1'b1, i, 4'b0000, 32'h0, 1'b1, lat);
    end
    cpu_req = 1'b0;

    repeat (5) @(negedge ACLK);
    checkOutput("queues_drained", 32'(cpuQ.size() + arQ.size() + awQ.size() + wQ.size()), 32'd0);
    finishTest();
  end

endmodule

// File: doc/dm_axi_master.md
DM_AXI_MASTER -- requirements
Module: dm_axi_master

Interface
REQ-001 SHALL have parameter MASTER_ID, default 4'd1, driven on AWID/ARID.
REQ-002 SHALL have port ACLK, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port ARESETn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cpu_req, input, 1, data-memory access request from the CPU LSU.
REQ-005 SHALL have port cpu_we, input, 4, byte write-enable mask, active high; 4'b0000 means read.
REQ-006 SHALL have port cpu_addr, input, 32, byte address.
REQ-007 SHALL have port cpu_wdata, input, 32, store data.
REQ-008 SHALL have port cpu_rdata, output, 32, load data.
REQ-009 SHALL have port cpu_stall, output, 1, CPU pipeline hold.
REQ-010 SHALL have port cpu_err, output, 1, one-cycle pulse on a non-OKAY response.
REQ-011 SHALL have AW channel ports: AWID out 4, AWADDR out 32, AWLEN out 4, AWSIZE out 3, AWBURST out 2, AWVALID out 1, AWREADY in 1.
REQ-012 SHALL have W channel ports: WDATA out 32, WSTRB out 4, WLAST out 1, WVALID out 1, WREADY in 1.
REQ-013 SHALL have B channel ports: BID in 4, BRESP in 2, BVALID in 1, BREADY out 1.
REQ-014 SHALL have AR channel ports: ARID out 4, ARADDR out 32, ARLEN out 4, ARSIZE out 3, ARBURST out 2, ARVALID out 1, ARREADY in 1.
REQ-015 SHALL have R channel ports: RID in 4, RDATA in 32, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1.

Function
REQ-016 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
- IDLE, cpu_req=1, cpu_we=0: go to RD_ADDR.
- IDLE, cpu_req=1, cpu_we!=0: go to WR_REQ.
REQ-017 SHALL register cpu_addr, cpu_we and cpu_wdata on leaving IDLE; AXI outputs come only from these registers.
REQ-018 SHALL make every transfer single-beat: xLEN=0, xSIZE=3'b010, xBURST=2'b01 (INCR), WLAST=1 whenever WVALID=1.
REQ-019 RD_ADDR SHALL hold ARVALID=1 until the ARVALID&ARREADY cycle, then go to RD_DATA.
REQ-020 RD_DATA SHALL hold RREADY=1 and return to IDLE on RVALID&RREADY&RLAST.
REQ-021 WR_REQ SHALL assert AWVALID and WVALID together, in either order of handshake.
- Each valid drops the cycle after its own handshake (flags aw_done, w_done).
- Go to WR_RESP when both are done; a same-cycle double handshake goes directly.
REQ-022 WR_REQ SHALL drive WSTRB from the registered cpu_we and WDATA from the registered cpu_wdata.
REQ-023 WR_RESP SHALL hold BREADY=1 and return to IDLE on BVALID&BREADY.
REQ-024 cpu_stall SHALL be combinational: 1 when (IDLE & cpu_req) or (state!=IDLE & no completing R/B handshake this cycle); else 0.
REQ-025 cpu_rdata SHALL equal RDATA during the completing R handshake and the registered copy of RDATA at all other times.
REQ-026 cpu_err SHALL pulse for one cycle, registered, after a completing handshake whose RRESP/BRESP is not 2'b00; the transaction completes normally.
REQ-027 SHALL never assert a VALID without the matching FSM state, and SHALL never drop a VALID before its handshake.
REQ-028 A new cpu_req SHALL be accepted in IDLE on the cycle after completion; there is no back-to-back bypass.
REQ-029 RID and BID SHALL be ignored for control.

Reset
REQ-030 ARESETn=0 SHALL asynchronously force state=IDLE, all VALID/READY outputs 0, cpu_rdata register 32'h0, cpu_err 0, aw_done/w_done 0, address/data registers 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction without completing any pending handshake.

Structure
REQ-032 AXI widths, BURST_INCR, SIZE_WORD and RESP_OKAY SHALL come from the shared AXI package/define header; the FSM state enum SHALL be local.
REQ-033 SHALL be one flat module with no sub-modules.

Verification
REQ-034 Read, addr 32'h0001_0010, ARREADY at cycle 2, RDATA 32'hDEAD_BEEF at cycle 4 -> ARADDR matches, cpu_rdata=32'hDEAD_BEEF, cpu_stall low exactly at the R handshake.
REQ-035 Write, cpu_we=4'b0011, data 32'h1234_5678, WREADY 2 cycles before AWREADY -> WVALID drops first, one B handshake, WSTRB=4'b0011.
REQ-036 Write with AWREADY=WREADY=1 in the same cycle -> WR_RESP next cycle, total 3 cycles to completion with BVALID immediate.
REQ-037 Read with RRESP=2'b10 -> cpu_err pulses exactly one cycle, FSM returns to IDLE.
REQ-038 ARESETn pulled low while in WR_REQ with AWVALID high -> all VALIDs 0 immediately, state IDLE, cpu_stall follows cpu_req after release.
REQ-039 Back-to-back load then store with cpu_req held -> two transactions, one idle cycle between, correct channel order.
